// File: rtl/pipelined_prefix_adder.sv
// rtl/pipelined_prefix_adder.sv - Kogge-Stone adder/subtractor, one level per stage, valid/ready stall.
// Optional macro PPA_OVERFLOW_EN adds the registered two's-complement overflow output ovf.
module pipelined_prefix_adder #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [TAG_W-1:0] out_tag
`ifdef PPA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int LOG = $clog2(WIDTH);

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub | cin;

  // Stage k holds the group generate/propagate after k prefix levels; index 0 is the input encoding.
  logic [LOG:0]                 v_q;
  logic [LOG:0]                 c0_q;
  logic [LOG:0][WIDTH-1:0]      g_q, g_d;
  logic [LOG-1:0][WIDTH-1:0]    p_q, p_d;
  logic [LOG:0][WIDTH-1:0]      a_q, b_q;
  logic [LOG:0][TAG_W-1:0]      tag_q;
  logic [WIDTH-1:0]             carry_in;

  // Carry-in is folded into bit 0's generate, so the final g is the carry out of each bit.
  assign g_d[0] = {a[WIDTH-1:1] & b_eff[WIDTH-1:1],
                   (a[0] & b_eff[0]) | ((a[0] ^ b_eff[0]) & c0)};
  assign p_d[0] = a ^ b_eff;

  genvar k, i;
  generate
    for (k = 0; k < LOG; k++) begin : g_level
      localparam int D = 1 << k;
      for (i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= D) begin : g_comb
          assign g_d[k+1][i] = g_q[k][i] | (p_q[k][i] & g_q[k][i-D]);
          if (k + 1 < LOG) begin : g_prop
            assign p_d[k+1][i] = p_q[k][i] & p_q[k][i-D];
          end
        end else begin : g_pass
          assign g_d[k+1][i] = g_q[k][i];
          if (k + 1 < LOG) begin : g_prop
            assign p_d[k+1][i] = p_q[k][i];
          end
        end
      end
    end
  endgenerate

  assign carry_in = {g_q[LOG][WIDTH-2:0], c0_q[LOG]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= '0;
      c0_q      <= '0;
      g_q       <= '0;
      p_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      out_tag   <= '0;
`ifdef PPA_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else if (!stall) begin
      v_q       <= {v_q[LOG-1:0], in_valid};
      c0_q      <= {c0_q[LOG-1:0], c0};
      g_q       <= g_d;
      p_q       <= p_d;
      a_q       <= {a_q[LOG-1:0], a};
      b_q       <= {b_q[LOG-1:0], b_eff};
      tag_q     <= {tag_q[LOG-1:0], in_tag};
      out_valid <= v_q[LOG];
      sum       <= a_q[LOG] ^ b_q[LOG] ^ carry_in;
      cout      <= g_q[LOG][WIDTH-1];
      out_tag   <= tag_q[LOG];
`ifdef PPA_OVERFLOW_EN
      ovf       <= g_q[LOG][WIDTH-2] ^ g_q[LOG][WIDTH-1];
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// tb/tb_pipelined_prefix_adder.sv - self-checking bench for pipelined_prefix_adder.
module tb_pipelined_prefix_adder;
  localparam int W  = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  a, b;
  logic          cin, sub;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic [TW-1:0] out_tag;
`ifdef PPA_OVERFLOW_EN
  logic          ovf;
`endif

  int total = 0;
  int bad   = 0;

  // Expected entries: {tag, ovf, cout, sum}
  logic [W+TW+1:0] exp_q[$];

  pipelined_prefix_adder #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .out_tag(out_tag)
`ifdef PPA_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic; returns {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                         input logic ci, input logic si);
    logic [W:0] r;
    logic       ov;
    if (si) begin
      r[W-1:0] = ai - bi;
      r[W]     = (ai >= bi);
      ov       = (ai[W-1] != bi[W-1]) && (r[W-1] != ai[W-1]);
    end else begin
      r  = {1'b0, ai} + {1'b0, bi} + {{W{1'b0}}, ci};
      ov = (ai[W-1] == bi[W-1]) && (r[W-1] != ai[W-1]);
    end
    return {ov, r};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic ci, input logic si, input logic [TW-1:0] ti,
                       input logic ordy);
    @(negedge clk);
    in_valid = v; a = ai; b = bi; cin = ci; sub = si; in_tag = ti; out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0 || cout !== 1'b0 || out_tag !== '0) begin
      bad++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b sum=%h cout=%b tag=%h, want 0 1 0 0 0",
               out_valid, in_ready, sum, cout, out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                                  input logic si, input logic [TW-1:0] ti,
                                  input logic [W-1:0] es, input logic ec, input logic eo);
    drive(1'b1, ai, bi, ci, si, ti, 1'b1);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL dir_accept: in_ready=%b want 1", in_ready);
    end
    @(posedge clk);
    for (int c = 0; c <= 7; c++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
      total++;
      if (out_valid !== (c == 6)) begin
        bad++;
        $display("FAIL dir_latency: cycle %0d out_valid=%b want %b", c, out_valid, c == 6);
      end
      if (c == 6) begin
        total++;
        if (sum !== es || cout !== ec || out_tag !== ti) begin
          bad++;
          $display("FAIL dir_result: sum=%h cout=%b tag=%h want sum=%h cout=%b tag=%h",
                   sum, cout, out_tag, es, ec, ti);
        end
`ifdef PPA_OVERFLOW_EN
        total++;
        if (ovf !== eo) begin
          bad++;
          $display("FAIL dir_ovf: ovf=%b want %b", ovf, eo);
        end
`else
        if (eo === 1'bx) $display("unexpected x expectation");
`endif
      end
      @(posedge clk);
    end
  endtask

  task automatic run_stream(input int n, input bit window, input int max_cycles);
    logic [W-1:0]  op_a, op_b, prev_sum;
    logic          op_c, op_s, ordy, prev_stall, prev_cout;
    logic [TW-1:0] op_t, prev_tag;
    logic [W+1:0]  m;
    logic [W+TW+1:0] e;
    int sent = 0, got = 0, cyc = 0;
    prev_stall = 1'b0; prev_sum = '0; prev_cout = 1'b0; prev_tag = '0;
    op_a = pick_operand(); op_b = pick_operand();
    op_c = 1'($urandom); op_s = 1'($urandom); op_t = TW'($urandom);
    while (got < n && cyc < max_cycles) begin
      ordy = window ? !(cyc >= 3 && cyc <= 9) : ($urandom_range(0, 3) != 0);
      drive(sent < n && (window || $urandom_range(0, 9) != 0), op_a, op_b, op_c, op_s, op_t, ordy);
      total++;
      if (in_ready !== !(out_valid && !ordy)) begin
        bad++;
        $display("FAIL stall_in_ready: cycle %0d in_ready=%b want %b", cyc, in_ready, !(out_valid && !ordy));
      end
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || sum !== prev_sum || cout !== prev_cout || out_tag !== prev_tag) begin
          bad++;
          $display("FAIL stall_hold: cycle %0d valid=%b sum=%h tag=%h want 1 %h %h",
                   cyc, out_valid, sum, out_tag, prev_sum, prev_tag);
        end
      end
      if (out_valid && ordy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL stream_extra: unexpected result sum=%h tag=%h", sum, out_tag);
        end else begin
          e = exp_q.pop_front();
          if ({out_tag, cout, sum} !== {e[W+TW+1:W+2], e[W:0]}) begin
            bad++;
            $display("FAIL stream_result: got tag=%h cout=%b sum=%h want tag=%h cout=%b sum=%h",
                     out_tag, cout, sum, e[W+TW+1:W+2], e[W], e[W-1:0]);
          end
`ifdef PPA_OVERFLOW_EN
          total++;
          if (ovf !== e[W+1]) begin
            bad++;
            $display("FAIL stream_ovf: ovf=%b want %b", ovf, e[W+1]);
          end
`endif
        end
        got++;
      end
      if (in_valid && in_ready) begin
        m = model(op_a, op_b, op_c, op_s);
        exp_q.push_back({op_t, m});
        sent++;
        op_a = pick_operand(); op_b = pick_operand();
        op_c = 1'($urandom); op_s = 1'($urandom); op_t = TW'($urandom);
      end
      prev_stall = out_valid && !ordy;
      prev_sum = sum; prev_cout = cout; prev_tag = out_tag;
      cyc++;
      @(posedge clk);
    end
    total++;
    if (got != n || exp_q.size() != 0) begin
      bad++;
      $display("FAIL stream_count: got=%0d want %0d, pending=%0d", got, n, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    run_stream(10, 1'b1, 80);
  endtask

  task automatic test_random();
    run_stream(10000, 1'b0, 40000);
  endtask

  task automatic test_reset_in_flight();
    int waited = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 3 + 1), 32'(i), 1'b0, 1'b0, TW'(8 + i), 1'b0);
      @(posedge clk);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    while (out_valid !== 1'b1 && waited < 20) begin
      @(posedge clk);
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      waited++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL flight_timeout: out_valid=%b want 1", out_valid);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0 || cout !== 1'b0 || out_tag !== '0) begin
      bad++;
      $display("FAIL flight_reset: out_valid=%b in_ready=%b sum=%h cout=%b tag=%h want 0 1 0 0 0",
               out_valid, in_ready, sum, cout, out_tag);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    test_directed_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 4'd5, 32'h2345_6789, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL flight_ghost: out_valid=%b tag=%h want no result", out_valid, out_tag);
      end
      @(posedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_tag = '0; out_ready = 1'b0;
    test_reset();
    test_directed_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd3, 32'h0, 1'b1, 1'b0);
    test_directed_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd1, 32'h8000_0000, 1'b0, 1'b1);
    test_directed_op(32'd5, 32'd7, 1'b0, 1'b1, 4'd2, 32'hFFFF_FFFE, 1'b0, 1'b0);
    test_directed_op(32'd7, 32'd5, 1'b1, 1'b1, 4'd4, 32'd2, 1'b1, 1'b0);
    test_back_to_back();
    test_reset_in_flight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
